// File: rtl/regfile_sb.sv
// Two-read / one-write register file with a per-register pending scoreboard for RAW hazard detection.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              ISSUE_V,
    input  logic [ADDR_W-1:0] ISSUE_RD,
    output logic              BUSY1,
    output logic              BUSY2,
    output logic [ADDR_W:0]   PEND_CNT
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                wr_v, set_v, inc, dec;
    logic [ADDR_W-1:0]   ra   [2];
    logic [DATA_W-1:0]   rd   [2];
    logic                busy [2];

    // In range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        wr_v   = WE3 && addr_ok(A3);
        set_v  = ISSUE_V && addr_ok(ISSUE_RD);
        regs_d = regs_q;
        pend_d = pend_q;
        inc    = 1'b0;
        dec    = 1'b0;
        if (wr_v) begin
            regs_d[A3] = WD3;
            pend_d[A3] = 1'b0;
            dec        = pend_q[A3];
        end
        // A new producer supersedes a retiring one on the same register.
        if (set_v) begin
            pend_d[ISSUE_RD] = 1'b1;
            inc              = !pend_q[ISSUE_RD];
            if (wr_v && (A3 == ISSUE_RD))
                dec = 1'b0;
        end
        cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ra[0] = A1;
    assign ra[1] = A2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p]   = '0;
            busy[p] = 1'b0;
            if (addr_ok(ra[p])) begin
                rd[p]   = regs_q[ra[p]];
                busy[p] = pend_q[ra[p]];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_v && (A3 == ra[p])) begin
                rd[p]   = WD3;
                busy[p] = set_v && (ISSUE_RD == ra[p]);
            end
`endif
            // Forwarded values must not leak out while reset is held.
            if (!rst) begin
                rd[p]   = '0;
                busy[p] = 1'b0;
            end
        end
    end

    assign RD1      = rd[0];
    assign RD2      = rd[1];
    assign BUSY1    = busy[0];
    assign BUSY2    = busy[1];
    assign PEND_CNT = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: expectations queued at stimulus, popped when outputs are sampled.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1, A2, A3, ISSUE_RD;
    logic [31:0] RD1, RD2, WD3;
    logic        WE3, ISSUE_V, BUSY1, BUSY2;
    logic [5:0]  PEND_CNT;

    string       tag_q [$];
    logic [31:0] val_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .ISSUE_V(ISSUE_V), .ISSUE_RD(ISSUE_RD),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .PEND_CNT(PEND_CNT)
    );

    always #5 clk = ~clk;

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (val_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_underrun: got %h required nothing", obs);
            return;
        end
        t = tag_q.pop_front();
        e = val_q.pop_front();
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: got %h required %h", t, obs, e);
        end
    endtask

    // Clock edge, then drop the one-shot controls and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
        WE3     = 1'b0;
        ISSUE_V = 1'b0;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; A1 = 5'd5; A2 = 5'd6; A3 = '0; WD3 = '0;
        WE3 = 1'b0; ISSUE_V = 1'b0; ISSUE_RD = '0;
        #2;
        push("reset_rd1", 32'h0);      pop(RD1);
        push("reset_busy2", 32'h0);    pop(32'(BUSY2));
        push("reset_pend", 32'h0);     pop(32'(PEND_CNT));
        #10 rst = 1'b1;

        // Write reg 5, issue reg 6, then reset mid-cycle.
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; ISSUE_V = 1'b1; ISSUE_RD = 5'd6;
        push("wr5_rd1", 32'hDEADBEEF); push("iss6_pend", 32'd1); push("iss6_busy2", 32'd1);
        tick();
        pop(RD1); pop(32'(PEND_CNT)); pop(32'(BUSY2));
        #1 rst = 1'b0;
        #1;
        push("midrst_rd1", 32'h0); push("midrst_pend", 32'h0); push("midrst_busy2", 32'h0);
        pop(RD1); pop(32'(PEND_CNT)); pop(32'(BUSY2));
        #1 rst = 1'b1;
        push("postrst_rd1", 32'h0); push("postrst_pend", 32'h0);
        tick();
        pop(RD1); pop(32'(PEND_CNT));

        // Hardwired zero register.
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'h12345678; ISSUE_V = 1'b1; ISSUE_RD = 5'd0; A1 = 5'd0;
        push("zero_rd1", 32'h0); push("zero_busy1", 32'h0); push("zero_pend", 32'h0);
        tick();
        pop(RD1); pop(32'(BUSY1)); pop(32'(PEND_CNT));

        // Issue / writeback lifecycle on reg 7.
        ISSUE_V = 1'b1; ISSUE_RD = 5'd7; A1 = 5'd7;
        push("life_busy1", 32'd1); push("life_pend", 32'd1);
        tick();
        pop(32'(BUSY1)); pop(32'(PEND_CNT));
        WE3 = 1'b1; A3 = 5'd7; WD3 = 32'hA5A5A5A5;
        push("wb7_busy1", 32'd0); push("wb7_rd1", 32'hA5A5A5A5); push("wb7_pend", 32'd0);
        tick();
        pop(32'(BUSY1)); pop(RD1); pop(32'(PEND_CNT));

        // Simultaneous set and clear.
        ISSUE_V = 1'b1; ISSUE_RD = 5'd3; A1 = 5'd3;
        push("iss3_pend", 32'd1);
        tick();
        pop(32'(PEND_CNT));
        ISSUE_V = 1'b1; ISSUE_RD = 5'd3; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h33333333;
        push("same_busy1", 32'd1); push("same_rd1", 32'h33333333); push("same_pend", 32'd1);
        tick();
        pop(32'(BUSY1)); pop(RD1); pop(32'(PEND_CNT));
        ISSUE_V = 1'b1; ISSUE_RD = 5'd4; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h44444444; A2 = 5'd4;
        push("diff_busy3", 32'd0); push("diff_busy4", 32'd1); push("diff_pend", 32'd1);
        push("diff_rd1", 32'h44444444);
        tick();
        pop(32'(BUSY1)); pop(32'(BUSY2)); pop(32'(PEND_CNT)); pop(RD1);
        WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h0;
        push("ret4_pend", 32'd0);
        tick();
        pop(32'(PEND_CNT));

        // Fill and drain the scoreboard.
        for (int r = 1; r < 32; r++) begin
            ISSUE_V = 1'b1; ISSUE_RD = 5'(r);
            tick();
        end
        push("full_pend", 32'd31);
        pop(32'(PEND_CNT));
        ISSUE_V = 1'b1; ISSUE_RD = 5'd5;
        push("reissue_pend", 32'd31);
        tick();
        pop(32'(PEND_CNT));
        for (int r = 1; r < 32; r++) begin
            WE3 = 1'b1; A3 = 5'(r); WD3 = 32'h10000000 + 32'(r);
            tick();
        end
        push("drain_pend", 32'd0);
        pop(32'(PEND_CNT));
        WE3 = 1'b1; A3 = 5'd2; WD3 = 32'h22222222; A1 = 5'd2; A2 = 5'd31;
        push("nopend_wr_pend", 32'd0); push("nopend_wr_rd1", 32'h22222222);
        push("drain_rd31", 32'h1000001F);
        tick();
        pop(32'(PEND_CNT)); pop(RD1); pop(RD2);

        // Forwarding window on reg 9.
        ISSUE_V = 1'b1; ISSUE_RD = 5'd9;
        tick();
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h00C0FFEE; A1 = 5'd9; A2 = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("byp_rd1", 32'h00C0FFEE); push("byp_rd2", 32'h00C0FFEE); push("byp_busy1", 32'd0);
`else
        push("byp_rd1", 32'h10000009); push("byp_rd2", 32'h10000009); push("byp_busy1", 32'd1);
`endif
        pop(RD1); pop(RD2); pop(32'(BUSY1));
        push("byp_next_rd1", 32'h00C0FFEE); push("byp_next_busy1", 32'd0);
        push("byp_next_pend", 32'd0);
        tick();
        pop(RD1); pop(32'(BUSY1)); pop(32'(PEND_CNT));

        n_cmp++;
        assert (val_q.size() == 0) else begin
            n_bad++;
            $error("FAIL scoreboard_leftover: got %0d required 0", val_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
